hsv_param_ctrl: RTL and testbench

HSV_PARAM_CTRL -- requirements
Module: hsv_param_ctrl

---
 rtl/hsv_param_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_hsv_param_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_param_ctrl.sv
// HsvParamCtrl: button and auto-rotation driven HSV parameter controller.
//
// Three channels (Hue, Saturation, Value) are each adjusted by a pair of
// raw push buttons. Every button is synchronised and debounced, then a
// per-channel state machine turns the held command into one immediate
// step followed, after a hold delay, by periodic auto-repeat steps. Hue
// wraps around its range, while Saturation and Value clamp at their ends.
// Hue can also rotate on its own from a free-running timer when sw_auto
// is set and no Hue button is in use.
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   reset      - asynchronous, active-low reset
//   btn_up     - raw increment buttons {Value, Saturation, Hue}
//   btn_dn     - raw decrement buttons, same bit mapping as btn_up
//   sw_auto    - enables automatic Hue rotation
//   sw_dir     - automatic rotation direction, 0 = up, 1 = down
//   Hue        - current hue, registered
//   Saturation - current saturation, registered
//   Value      - current value, registered
//   step_evt   - one-cycle pulse per channel when its output changes
module hsv_param_ctrl #(
   parameter int W        = 9,
   parameter int HUE_MAX  = 359,
   parameter int SV_MAX   = 100,
   parameter int DB_CYC   = 1000000,
   parameter int RPT_DLY  = 25000000,
   parameter int RPT_PER  = 5000000,
   parameter int AUTO_PER = 1048576
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [2:0]   btn_up,
   input  logic [2:0]   btn_dn,
   input  logic         sw_auto,
   input  logic         sw_dir,
   output logic [W-1:0] Hue,
   output logic [W-1:0] Saturation,
   output logic [W-1:0] Value,
   output logic [2:0]   step_evt
);

   localparam int DBW  = $clog2(DB_CYC + 1);
   localparam int TMAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int AW   = $clog2(AUTO_PER + 1);

   typedef enum logic [1:0] {IDLE, FIRST, WAIT, REPEAT} state_t;

   logic [5:0]     meta;
   logic [5:0]     sync;
   logic [5:0]     db;
   logic [DBW-1:0] dbCnt [6];

   logic [2:0]     cmdValid;
   logic [2:0]     cmdDown;
   logic [2:0]     sameDir;
   logic [2:0]     stepReq;
   logic [2:0]     dirDown;
   state_t         state [3];
   logic [TW-1:0]  timer [3];

   logic [AW-1:0]  autoCnt;
   logic           autoRun;
   logic           autoTick;
   logic           hueStep;
   logic           hueDown;

   logic [W-1:0]   hueNext;
   logic [W-1:0]   satNext;
   logic [W-1:0]   valNext;

   // Two-flop synchroniser for all six raw buttons. Bits 2:0 carry the
   // up buttons and bits 5:3 the down buttons. Reset clears them to
   // released so held buttons look freshly pressed once reset lifts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= {btn_dn, btn_up};
         sync <= meta;
      end
   end

   // Debouncer: a new level is taken only after DB_CYC consecutive
   // synchronised samples that differ from the accepted level. Any sample
   // that agrees with the accepted level restarts the count, so short
   // glitches never get through.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db <= '0;
         for (int i = 0; i < 6; i++) begin
            dbCnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (sync[i] == db[i]) begin
               dbCnt[i] <= '0;
            end else if (dbCnt[i] == DBW'(DB_CYC - 1)) begin
               db[i]    <= sync[i];
               dbCnt[i] <= '0;
            end else begin
               dbCnt[i] <= dbCnt[i] + 1'b1;
            end
         end
      end
   end

   // Decode each channel's debounced command. Exactly one button held is
   // a valid command; both or neither means no command. sameDir says the
   // command still matches the direction latched when the press started,
   // which is what keeps a state machine out of IDLE.
   always_comb begin
      cmdValid = db[2:0] ^ db[5:3];
      cmdDown  = db[5:3];
      sameDir  = '0;
      stepReq  = '0;
      for (int c = 0; c < 3; c++) begin
         sameDir[c] = cmdValid[c] && (cmdDown[c] == dirDown[c]);
         case (state[c])
            FIRST:   stepReq[c] = sameDir[c];
            REPEAT:  stepReq[c] = sameDir[c] && (timer[c] == TW'(RPT_PER - 1));
            default: stepReq[c] = 1'b0;
         endcase
      end
   end

   // Per-channel press/hold state machine. FIRST issues the immediate
   // step, WAIT burns the hold delay, and REPEAT steps once per period.
   // Releasing the button or reversing direction mid-press drops back to
   // IDLE and clears the timer, so a reversal needs a fresh press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dirDown <= '0;
         for (int c = 0; c < 3; c++) begin
            state[c] <= IDLE;
            timer[c] <= '0;
         end
      end else begin
         for (int c = 0; c < 3; c++) begin
            case (state[c])
               IDLE: begin
                  timer[c] <= '0;
                  if (cmdValid[c]) begin
                     state[c]   <= FIRST;
                     dirDown[c] <= cmdDown[c];
                  end
               end
               FIRST: begin
                  timer[c] <= '0;
                  state[c] <= sameDir[c] ? WAIT : IDLE;
               end
               WAIT: begin
                  if (!sameDir[c]) begin
                     state[c] <= IDLE;
                     timer[c] <= '0;
                  end else if (timer[c] == TW'(RPT_DLY - 1)) begin
                     state[c] <= REPEAT;
                     timer[c] <= '0;
                  end else begin
                     timer[c] <= timer[c] + 1'b1;
                  end
               end
               REPEAT: begin
                  if (!sameDir[c]) begin
                     state[c] <= IDLE;
                     timer[c] <= '0;
                  end else if (timer[c] == TW'(RPT_PER - 1)) begin
                     timer[c] <= '0;
                  end else begin
                     timer[c] <= timer[c] + 1'b1;
                  end
               end
               default: begin
                  state[c] <= IDLE;
                  timer[c] <= '0;
               end
            endcase
         end
      end
   end

   // Automatic Hue rotation only runs while the Hue buttons are idle and
   // no new Hue command is arriving. A press landing on the same cycle as
   // a tick therefore suppresses the tick, and the counter starts over
   // from zero once the buttons are released again.
   always_comb begin
      autoRun  = sw_auto && (state[0] == IDLE) && !cmdValid[0];
      autoTick = autoRun && (autoCnt == AW'(AUTO_PER - 1));
   end

   // Free-running auto-rotation counter, held at zero whenever automatic
   // rotation is not allowed to run.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         autoCnt <= '0;
      end else if (!autoRun || autoTick) begin
         autoCnt <= '0;
      end else begin
         autoCnt <= autoCnt + 1'b1;
      end
   end

   // Next output values. Hue wraps at both ends of its range. Saturation
   // and Value hold at their limits, so a blocked step leaves the value
   // untouched and step_evt quiet. Button steps on Hue take priority over
   // the automatic direction.
   always_comb begin
      hueStep = stepReq[0] | autoTick;
      hueDown = stepReq[0] ? dirDown[0] : sw_dir;
      hueNext = Hue;
      satNext = Saturation;
      valNext = Value;
      if (hueStep) begin
         if (hueDown) begin
            hueNext = (Hue == '0) ? W'(HUE_MAX) : Hue - 1'b1;
         end else begin
            hueNext = (Hue >= W'(HUE_MAX)) ? '0 : Hue + 1'b1;
         end
      end
      if (stepReq[1]) begin
         if (dirDown[1]) begin
            satNext = (Saturation == '0) ? Saturation : Saturation - 1'b1;
         end else begin
            satNext = (Saturation >= W'(SV_MAX)) ? W'(SV_MAX) : Saturation + 1'b1;
         end
      end
      if (stepReq[2]) begin
         if (dirDown[2]) begin
            valNext = (Value == '0) ? Value : Value - 1'b1;
         end else begin
            valNext = (Value >= W'(SV_MAX)) ? W'(SV_MAX) : Value + 1'b1;
         end
      end
   end

   // Output registers. step_evt is raised only where the register
   // actually changes value in this update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Hue        <= '0;
         Saturation <= '0;
         Value      <= '0;
         step_evt   <= '0;
      end else begin
         Hue        <= hueNext;
         Saturation <= satNext;
         Value      <= valNext;
         step_evt   <= {valNext != Value, satNext != Saturation, hueNext != Hue};
      end
   end

endmodule

// File: tb/tb_hsv_param_ctrl.sv
// TbHsvParamCtrl: self-checking bench for hsv_param_ctrl with shortened
// timing (DB_CYC=4, RPT_DLY=20, RPT_PER=5, AUTO_PER=8). Each scenario
// task pushes the values it expects each channel to step through into a
// per-channel queue; a monitor pops and compares on every step_evt pulse
// and records the cycle of each step for timing checks.
module tb_hsv_param_ctrl;

   localparam int W        = 9;
   localparam int HUE_MAX  = 359;
   localparam int SV_MAX   = 100;
   localparam int DB_CYC   = 4;
   localparam int RPT_DLY  = 20;
   localparam int RPT_PER  = 5;
   localparam int AUTO_PER = 8;

   logic         clk;
   logic         reset;
   logic [2:0]   btn_up;
   logic [2:0]   btn_dn;
   logic         sw_auto;
   logic         sw_dir;
   logic [W-1:0] Hue;
   logic [W-1:0] Saturation;
   logic [W-1:0] Value;
   logic [2:0]   step_evt;

   logic [W-1:0] expQ [3][$];
   int           stepTimes [3][$];
   logic [W-1:0] lastVal [3];
   logic [W-1:0] obs [3];
   logic [W-1:0] expV;
   int           vectors = 0;
   int           miscompares = 0;
   int           cycle = 0;

   hsv_param_ctrl #(
      .W(W), .HUE_MAX(HUE_MAX), .SV_MAX(SV_MAX), .DB_CYC(DB_CYC),
      .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER), .AUTO_PER(AUTO_PER)
   ) dut (
      .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn),
      .sw_auto(sw_auto), .sw_dir(sw_dir), .Hue(Hue), .Saturation(Saturation),
      .Value(Value), .step_evt(step_evt)
   );

   // Free-running clock and a cycle counter used to time-stamp steps.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Scoreboard monitor: on each falling edge, a step_evt pulse must match
   // the next queued value for that channel, and without a pulse the
   // channel output must hold its previous value.
   always @(negedge clk) begin
      obs[0] = Hue;
      obs[1] = Saturation;
      obs[2] = Value;
      if (!reset) begin
         for (int c = 0; c < 3; c++) lastVal[c] = '0;
      end else begin
         for (int c = 0; c < 3; c++) begin
            vectors++;
            if (step_evt[c]) begin
               stepTimes[c].push_back(cycle);
               if (expQ[c].size() == 0) begin
                  miscompares++;
                  $display("[TB] FAIL unexpected_step ch%0d: got value %0d at cycle %0d, expected no step", c, obs[c], cycle);
               end else begin
                  expV = expQ[c].pop_front();
                  if (obs[c] !== expV) begin
                     miscompares++;
                     $display("[TB] FAIL step_value ch%0d: got %0d, expected %0d", c, obs[c], expV);
                  end
               end
            end else if (obs[c] !== lastVal[c]) begin
               miscompares++;
               $display("[TB] FAIL silent_change ch%0d: got %0d, expected %0d", c, obs[c], lastVal[c]);
            end
            lastVal[c] = obs[c];
         end
      end
   end

   // Reset state: all outputs zero while reset is held low.
   task automatic test_reset();
      reset = 1'b0;
      #3;
      vectors += 4;
      if (Hue !== '0) begin miscompares++; $display("[TB] FAIL reset_hue: got %0d, expected 0", Hue); end
      if (Saturation !== '0) begin miscompares++; $display("[TB] FAIL reset_sat: got %0d, expected 0", Saturation); end
      if (Value !== '0) begin miscompares++; $display("[TB] FAIL reset_val: got %0d, expected 0", Value); end
      if (step_evt !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_evt: got %b, expected 000", step_evt); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (5) @(posedge clk);
   endtask

   // A 3-cycle Saturation-up glitch is filtered; a 10-cycle press gives
   // exactly one step.
   task automatic test_short_pulse();
      @(posedge clk); #1 btn_up[1] = 1'b1;
      repeat (3) @(posedge clk); #1 btn_up[1] = 1'b0;
      repeat (20) @(posedge clk);
      vectors += 2;
      if (Saturation !== '0) begin miscompares++; $display("[TB] FAIL glitch_sat: got %0d, expected 0", Saturation); end
      if (stepTimes[1].size() != 0) begin miscompares++; $display("[TB] FAIL glitch_steps: got %0d, expected 0", stepTimes[1].size()); end
      expQ[1].push_back(9'd1);
      #1 btn_up[1] = 1'b1;
      repeat (10) @(posedge clk); #1 btn_up[1] = 1'b0;
      repeat (40) @(posedge clk);
      vectors += 2;
      if (Saturation !== 9'd1) begin miscompares++; $display("[TB] FAIL press_sat: got %0d, expected 1", Saturation); end
      if (stepTimes[1].size() != 1) begin miscompares++; $display("[TB] FAIL press_steps: got %0d, expected 1", stepTimes[1].size()); end
   endtask

   // Hue-down held from 0: wrap to 359, then repeat at RPT_PER spacing.
   // Releasing right after the third step still lets one more repeat step
   // through while the release is being debounced.
   task automatic test_hue_repeat();
      expQ[0].push_back(9'd359);
      expQ[0].push_back(9'd358);
      expQ[0].push_back(9'd357);
      expQ[0].push_back(9'd356);
      @(posedge clk); #1 btn_dn[0] = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (stepTimes[0].size() >= 3) break;
      end
      #1 btn_dn[0] = 1'b0;
      vectors++;
      if (stepTimes[0].size() < 3) begin miscompares++; $display("[TB] FAIL hue_repeat_timeout: got %0d steps, expected 3", stepTimes[0].size()); end
      repeat (30) @(posedge clk);
      vectors += 2;
      if (Hue !== 9'd356) begin miscompares++; $display("[TB] FAIL hue_repeat_final: got %0d, expected 356", Hue); end
      if (stepTimes[0].size() != 4) begin miscompares++; $display("[TB] FAIL hue_repeat_count: got %0d, expected 4", stepTimes[0].size()); end
      if (stepTimes[0].size() == 4) begin
         vectors += 3;
         if (stepTimes[0][1] - stepTimes[0][0] < RPT_DLY || stepTimes[0][1] - stepTimes[0][0] > RPT_DLY + RPT_PER + 1) begin
            miscompares++; $display("[TB] FAIL hold_delay: got %0d cycles, expected %0d..%0d", stepTimes[0][1] - stepTimes[0][0], RPT_DLY, RPT_DLY + RPT_PER + 1);
         end
         if (stepTimes[0][2] - stepTimes[0][1] != RPT_PER) begin
            miscompares++; $display("[TB] FAIL repeat_gap1: got %0d, expected %0d", stepTimes[0][2] - stepTimes[0][1], RPT_PER);
         end
         if (stepTimes[0][3] - stepTimes[0][2] != RPT_PER) begin
            miscompares++; $display("[TB] FAIL repeat_gap2: got %0d, expected %0d", stepTimes[0][3] - stepTimes[0][2], RPT_PER);
         end
      end
   endtask

   // Value-up held for 2000 cycles: climbs to SV_MAX and then stops pulsing.
   task automatic test_value_clamp();
      for (int v = 1; v <= SV_MAX; v++) expQ[2].push_back(W'(v));
      @(posedge clk); #1 btn_up[2] = 1'b1;
      repeat (2000) @(posedge clk);
      #1 btn_up[2] = 1'b0;
      repeat (30) @(posedge clk);
      vectors += 2;
      if (Value !== W'(SV_MAX)) begin miscompares++; $display("[TB] FAIL clamp_val: got %0d, expected %0d", Value, SV_MAX); end
      if (stepTimes[2].size() != SV_MAX) begin miscompares++; $display("[TB] FAIL clamp_steps: got %0d, expected %0d", stepTimes[2].size(), SV_MAX); end
   endtask

   // Auto rotation up through 358 -> 359 -> 0 at AUTO_PER spacing, then a
   // button press timed to land on the next auto tick gives a single step.
   task automatic test_auto_hue();
      int tA;
      stepTimes[0].delete();
      expQ[0].push_back(9'd357);
      expQ[0].push_back(9'd358);
      expQ[0].push_back(9'd359);
      expQ[0].push_back(9'd0);
      @(posedge clk); #1 begin sw_dir = 1'b0; sw_auto = 1'b1; end
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (stepTimes[0].size() >= 4) break;
      end
      vectors++;
      if (stepTimes[0].size() < 4) begin
         miscompares++; $display("[TB] FAIL auto_timeout: got %0d steps, expected 4", stepTimes[0].size());
      end else begin
         vectors += 2;
         if (stepTimes[0][2] - stepTimes[0][1] != AUTO_PER) begin
            miscompares++; $display("[TB] FAIL auto_gap_359: got %0d, expected %0d", stepTimes[0][2] - stepTimes[0][1], AUTO_PER);
         end
         if (stepTimes[0][3] - stepTimes[0][2] != AUTO_PER) begin
            miscompares++; $display("[TB] FAIL auto_gap_wrap: got %0d, expected %0d", stepTimes[0][3] - stepTimes[0][2], AUTO_PER);
         end
         tA = stepTimes[0][3];
         expQ[0].push_back(9'd1);
         #1 btn_up[0] = 1'b1;
         for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (stepTimes[0].size() >= 5) break;
         end
         #1 begin btn_up[0] = 1'b0; sw_auto = 1'b0; end
         vectors++;
         if (stepTimes[0].size() < 5) begin
            miscompares++; $display("[TB] FAIL coincide_timeout: got %0d steps, expected 5", stepTimes[0].size());
         end else if (stepTimes[0][4] - tA < AUTO_PER) begin
            miscompares++; $display("[TB] FAIL coincide_early: got step %0d cycles after tick, expected >= %0d", stepTimes[0][4] - tA, AUTO_PER);
         end
      end
      repeat (30) @(posedge clk);
      vectors += 2;
      if (Hue !== 9'd1) begin miscompares++; $display("[TB] FAIL coincide_hue: got %0d, expected 1", Hue); end
      if (stepTimes[0].size() != 5) begin miscompares++; $display("[TB] FAIL coincide_count: got %0d, expected 5", stepTimes[0].size()); end
   endtask

   // Both Saturation buttons pressed together: no command, no step.
   task automatic test_both_pressed();
      int n;
      n = stepTimes[1].size();
      @(posedge clk); #1 begin btn_up[1] = 1'b1; btn_dn[1] = 1'b1; end
      repeat (40) @(posedge clk);
      #1 begin btn_up[1] = 1'b0; btn_dn[1] = 1'b0; end
      repeat (20) @(posedge clk);
      vectors += 2;
      if (Saturation !== 9'd1) begin miscompares++; $display("[TB] FAIL both_sat: got %0d, expected 1", Saturation); end
      if (stepTimes[1].size() != n) begin miscompares++; $display("[TB] FAIL both_steps: got %0d, expected %0d", stepTimes[1].size(), n); end
   endtask

   // Saturation-up and Value-down pressed together step in the same cycle.
   task automatic test_back_to_back();
      int ns;
      int nv;
      ns = stepTimes[1].size();
      nv = stepTimes[2].size();
      expQ[1].push_back(9'd2);
      expQ[2].push_back(9'd99);
      @(posedge clk); #1 begin btn_up[1] = 1'b1; btn_dn[2] = 1'b1; end
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         if (stepTimes[1].size() > ns && stepTimes[2].size() > nv) break;
      end
      #1 begin btn_up[1] = 1'b0; btn_dn[2] = 1'b0; end
      vectors++;
      if (stepTimes[1].size() <= ns || stepTimes[2].size() <= nv) begin
         miscompares++; $display("[TB] FAIL multi_timeout: got %0d/%0d new steps, expected 1/1", stepTimes[1].size() - ns, stepTimes[2].size() - nv);
      end else if (stepTimes[1][ns] != stepTimes[2][nv]) begin
         miscompares++; $display("[TB] FAIL multi_same_cycle: got sat cycle %0d, expected val cycle %0d", stepTimes[1][ns], stepTimes[2][nv]);
      end
      repeat (20) @(posedge clk);
      vectors += 2;
      if (Saturation !== 9'd2) begin miscompares++; $display("[TB] FAIL multi_sat: got %0d, expected 2", Saturation); end
      if (Value !== 9'd99) begin miscompares++; $display("[TB] FAIL multi_val: got %0d, expected 99", Value); end
   endtask

   // Reset pulsed between edges during a Value-down repeat clears outputs
   // at once; a button held across release steps only after sync+debounce.
   task automatic test_reset_repeat();
      int relEdge;
      stepTimes[2].delete();
      expQ[2].push_back(9'd98);
      expQ[2].push_back(9'd97);
      expQ[2].push_back(9'd96);
      @(posedge clk); #1 btn_dn[2] = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         if (stepTimes[2].size() >= 3) break;
      end
      vectors++;
      if (stepTimes[2].size() < 3) begin miscompares++; $display("[TB] FAIL reset_rpt_timeout: got %0d steps, expected 3", stepTimes[2].size()); end
      for (int c = 0; c < 3; c++) begin expQ[c].delete(); stepTimes[c].delete(); end
      #3 reset = 1'b0;
      #1;
      vectors += 4;
      if (Hue !== '0) begin miscompares++; $display("[TB] FAIL async_hue: got %0d, expected 0", Hue); end
      if (Saturation !== '0) begin miscompares++; $display("[TB] FAIL async_sat: got %0d, expected 0", Saturation); end
      if (Value !== '0) begin miscompares++; $display("[TB] FAIL async_val: got %0d, expected 0", Value); end
      if (step_evt !== 3'b000) begin miscompares++; $display("[TB] FAIL async_evt: got %b, expected 000", step_evt); end
      btn_dn[2] = 1'b0;
      btn_up[2] = 1'b1;
      repeat (2) @(posedge clk);
      #4 reset = 1'b1;
      relEdge = cycle + 1;
      expQ[2].push_back(9'd1);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         if (stepTimes[2].size() >= 1) break;
      end
      #1 btn_up[2] = 1'b0;
      vectors++;
      if (stepTimes[2].size() < 1) begin
         miscompares++; $display("[TB] FAIL post_reset_timeout: got 0 steps, expected 1");
      end else if (stepTimes[2][0] - relEdge < DB_CYC + 2 || stepTimes[2][0] - relEdge > DB_CYC + 3) begin
         miscompares++; $display("[TB] FAIL post_reset_latency: got %0d cycles, expected %0d..%0d", stepTimes[2][0] - relEdge, DB_CYC + 2, DB_CYC + 3);
      end
      repeat (20) @(posedge clk);
      vectors += 2;
      if (Value !== 9'd1) begin miscompares++; $display("[TB] FAIL post_reset_val: got %0d, expected 1", Value); end
      if (stepTimes[2].size() != 1) begin miscompares++; $display("[TB] FAIL post_reset_count: got %0d, expected 1", stepTimes[2].size()); end
   endtask

   // Scenario sequence, leftover-expectation sweep and summary.
   initial begin
      reset   = 1'b0;
      btn_up  = '0;
      btn_dn  = '0;
      sw_auto = 1'b0;
      sw_dir  = 1'b0;
      for (int c = 0; c < 3; c++) lastVal[c] = '0;
      test_reset();
      test_short_pulse();
      test_hue_repeat();
      test_value_clamp();
      test_auto_hue();
      test_both_pressed();
      test_back_to_back();
      test_reset_repeat();
      for (int c = 0; c < 3; c++) begin
         vectors++;
         if (expQ[c].size() != 0) begin
            miscompares++; $display("[TB] FAIL leftover_expect ch%0d: got %0d pending, expected 0", c, expQ[c].size());
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
